jpeg_pingpong_block_ctrl: RTL and testbench
===========================================

Name: jpeg_pingpong_block_ctrl

Overview:
- Sequences a pair of 64-entry x 12-bit block buffers used in ping-pong fashion, both loaded in 1-pixel mode.
- Accepts a raster-ordered pixel stream with a valid/ready handshake and steers each pixel to the buffer currently filling.
- Counts 64 pixels per 8x8 block and presents each completed block to the downstream stage (DCT) with a valid/ready handshake.
- Sits between the level-shift/pixel front end and the DCT input.

Parameters:
- DATA_WIDTH, 12, pixel/sample width.
- BLK_CNT_W, 16, width of the per-frame released-block counter.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- pix_valid  in  1  upstream pixel valid.
- pix_ready  out  1  controller can accept a pixel.
- pix_data  in  DATA_WIDTH  pixel sample.
- pix_last  in  1  marks last pixel of frame; qualified by pix_valid.
- buf_wr_en  out  2  1-pixel write enable; bit0 drives buffer 0, bit1 drives buffer 1.
- buf_wr_data  out  DATA_WIDTH  write data to both buffers.
- pix_index  out  6  position within current block of next pixel to be written.
- blk_valid  out  1  a full block is available.
- blk_sel  out  1  buffer index holding the presented block.
- blk_last  out  1  presented block is last of frame.
- blk_ready  in  1  downstream consumes the presented block.
- blk_count  out  BLK_CNT_W  blocks released in current frame.
- err_last  out  1  sticky: pix_last seen off a block boundary.

Behaviour:
- Clock is clock. Reset is synchronous and active-high on port reset.
- The buffers' internal write indices are held in reset whenever reset is high. The top level ties each buffer's reset to the same source, so indices and the controller stay aligned.
- State:
  - wsel (1b): buffer being filled.
  - rsel (1b): buffer to present.
  - pix_cnt (6b).
  - full[1:0].
  - lastf[1:0].
  - blk_count.
  - err_last.
- Reset values: wsel=0, rsel=0, pix_cnt=0, full=0, lastf=0, blk_count=0, err_last=0. Outputs follow: pix_ready=1, buf_wr_en=0, blk_valid=0, blk_sel=0, blk_last=0, pix_index=0.
- Combinational outputs:
  - pix_ready = !full[wsel].
  - accept = pix_valid & pix_ready.
  - buf_wr_en[wsel] = accept; the other bit = 0.
  - buf_wr_data = pix_data.
  - pix_index = pix_cnt.
  - blk_valid = full[rsel]; blk_sel = rsel; blk_last = lastf[rsel].
- Per-buffer states: EMPTY (full=0, not wsel), FILLING (wsel, full=0), FULL (full=1). Transitions:
  - FILLING->FULL on the 64th accept.
  - FULL->EMPTY/FILLING on release.
- On accept:
  - If pix_cnt==63: pix_cnt<=0, full[wsel]<=1, lastf[wsel]<=pix_last, wsel<=~wsel.
  - Else: pix_cnt<=pix_cnt+1.
- Release = blk_valid & blk_ready: full[rsel]<=0, rsel<=~rsel.
  - If blk_last: blk_count<=0.
  - Else: blk_count<=blk_count+1 (wraps modulo 2^BLK_CNT_W).
- Latency:
  - 64th pixel accepted in cycle N -> blk_valid=1 in N+1.
  - Release in cycle M -> freed buffer's pix_ready (if it is wsel) =1 in M+1.
  - Release in cycle M with the other buffer full -> blk_valid stays 1 in M+1 with blk_sel flipped.
- Simultaneous accept-complete and release in the same cycle always target different buffers; both updates take effect.
- Both buffers full: pix_ready=0; pixels are stalled, never dropped. buf_wr_en stays 0.
- pix_last on an accepted pixel with pix_cnt!=63:
  - err_last<=1 (cleared only by reset).
  - The pixel is written normally, but not flagged.
  - Block counting continues unchanged; no partial-block flush.
- blk_ready while blk_valid=0 is ignored.
- pix_valid low: no state change except release.
- Reset mid-block or mid-handshake: all state returns to reset values the following cycle; partial and full blocks are discarded.

Test Plan:
- 64 pixels 0..63 back-to-back, blk_ready=0 -> buf_wr_en=01 for 64 cycles. Then blk_valid=1, blk_sel=0, blk_last=0, pix_index=0, buffer 0 holds 0..63.
- 128 pixels with blk_ready=0 -> both full. pix_ready=0 from the cycle after the 128th accept. Pixel 129 is held on the bus until blk_ready pulses, then is written to buffer 0 at index 0.
- Continuous stream of 256 pixels with blk_ready=1 -> blocks released alternately on sel 0,1,0,1. blk_count reads 1,2,3,4. pix_ready never drops.
- pix_last on pixel 127, then blk_ready -> second block released with blk_last=1. blk_count returns to 0. err_last=0.
- pix_last on pixel 40 -> err_last=1 from the next cycle and stays high. The block completes at pixel 63 with blk_last=0.
- reset asserted for 1 cycle at pixel 30 with buffer 1 full -> next cycle: blk_valid=0, pix_ready=1, pix_index=0, blk_count=0, err_last=0.

Source files
------------

// File: rtl/jpeg_pingpong_block_ctrl.sv
// Ping-pong controller for two 64-entry block buffers in front of the DCT.
// Steers raster pixels into the filling buffer and presents full blocks downstream.
module jpeg_pingpong_block_ctrl #(
    parameter int DATA_WIDTH = 12,
    parameter int BLK_CNT_W  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [DATA_WIDTH-1:0] pix_data,
    input  logic                  pix_last,
    output logic [1:0]            buf_wr_en,
    output logic [DATA_WIDTH-1:0] buf_wr_data,
    output logic [5:0]            pix_index,
    output logic                  blk_valid,
    output logic                  blk_sel,
    output logic                  blk_last,
    input  logic                  blk_ready,
    output logic [BLK_CNT_W-1:0]  blk_count,
    output logic                  err_last
);

    logic                 wsel_q, wsel_d;
    logic                 rsel_q, rsel_d;
    logic [5:0]           pix_cnt_q, pix_cnt_d;
    logic [1:0]           full_q, full_d;
    logic [1:0]           lastf_q, lastf_d;
    logic [BLK_CNT_W-1:0] blk_count_q, blk_count_d;
    logic                 err_last_q, err_last_d;

    logic accept;
    logic release_blk;
    logic blk_done;

    assign pix_ready   = ~full_q[wsel_q];
    assign accept      = pix_valid & pix_ready;
    assign blk_done    = accept & (pix_cnt_q == 6'd63);
    assign buf_wr_en   = accept ? (wsel_q ? 2'b10 : 2'b01) : 2'b00;
    assign buf_wr_data = pix_data;
    assign pix_index   = pix_cnt_q;
    assign blk_valid   = full_q[rsel_q];
    assign blk_sel     = rsel_q;
    assign blk_last    = lastf_q[rsel_q];
    assign blk_count   = blk_count_q;
    assign err_last    = err_last_q;
    assign release_blk = blk_valid & blk_ready;

    // A completing write and a release never hit the same buffer:
    // writing needs full[wsel]=0 while releasing needs full[rsel]=1.
    always_comb begin
        wsel_d      = wsel_q;
        rsel_d      = rsel_q;
        pix_cnt_d   = pix_cnt_q;
        full_d      = full_q;
        lastf_d     = lastf_q;
        blk_count_d = blk_count_q;
        err_last_d  = err_last_q;

        if (accept) begin
            if (blk_done) begin
                pix_cnt_d        = 6'd0;
                full_d[wsel_q]   = 1'b1;
                lastf_d[wsel_q]  = pix_last;
                wsel_d           = ~wsel_q;
            end else begin
                pix_cnt_d = pix_cnt_q + 6'd1;
                if (pix_last) begin
                    err_last_d = 1'b1;
                end
            end
        end

        if (release_blk) begin
            full_d[rsel_q] = 1'b0;
            rsel_d         = ~rsel_q;
            if (blk_last) begin
                blk_count_d = '0;
            end else begin
                blk_count_d = blk_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wsel_q      <= 1'b0;
            rsel_q      <= 1'b0;
            pix_cnt_q   <= 6'd0;
            full_q      <= 2'b00;
            lastf_q     <= 2'b00;
            blk_count_q <= '0;
            err_last_q  <= 1'b0;
        end else begin
            wsel_q      <= wsel_d;
            rsel_q      <= rsel_d;
            pix_cnt_q   <= pix_cnt_d;
            full_q      <= full_d;
            lastf_q     <= lastf_d;
            blk_count_q <= blk_count_d;
            err_last_q  <= err_last_d;
        end
    end

endmodule

// File: tb/tb_jpeg_pingpong_block_ctrl.sv
// Bench for jpeg_pingpong_block_ctrl: block-queue reference model, buffer
// images rebuilt from the write port and compared on every release.
module tb_jpeg_pingpong_block_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        pix_valid;
    logic        pix_ready;
    logic [11:0] pix_data;
    logic        pix_last;
    logic [1:0]  buf_wr_en;
    logic [11:0] buf_wr_data;
    logic [5:0]  pix_index;
    logic        blk_valid;
    logic        blk_sel;
    logic        blk_last;
    logic        blk_ready;
    logic [15:0] blk_count;
    logic        err_last;

    jpeg_pingpong_block_ctrl #(.DATA_WIDTH(12), .BLK_CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_last(pix_last),
        .buf_wr_en(buf_wr_en), .buf_wr_data(buf_wr_data),
        .pix_index(pix_index),
        .blk_valid(blk_valid), .blk_sel(blk_sel), .blk_last(blk_last),
        .blk_ready(blk_ready), .blk_count(blk_count), .err_last(err_last)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: completed blocks form a FIFO of depth two.
    bit           m_qlast[$];
    logic [767:0] m_qdata[$];
    logic [767:0] m_cur;
    int           m_done;
    int           m_rel;
    int           m_pcnt;
    int           m_bcount;
    bit           m_err;

    logic [11:0]  tmem[2][64];

    task automatic model_reset();
        m_qlast.delete();
        m_qdata.delete();
        m_cur    = '0;
        m_done   = 0;
        m_rel    = 0;
        m_pcnt   = 0;
        m_bcount = 0;
        m_err    = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [11:0] d, input logic l,
                       input logic r, input logic rs);
        bit           acc;
        bit           rel;
        bit           exp_rdy;
        logic [1:0]   exp_en;
        logic [767:0] img;
        int           rb;
        pix_valid = v;
        pix_data  = d;
        pix_last  = l;
        blk_ready = r;
        reset     = rs;
        #1;
        exp_rdy = (m_qlast.size() < 2);
        acc     = v && exp_rdy;
        rel     = r && (m_qlast.size() > 0);
        exp_en  = acc ? ((m_done % 2) ? 2'b10 : 2'b01) : 2'b00;
        rb      = m_rel % 2;
        chk("pix_ready", 32'(pix_ready), 32'(exp_rdy));
        chk("buf_wr_en", 32'(buf_wr_en), 32'(exp_en));
        chk("pix_index", 32'(pix_index), 32'(m_pcnt));
        chk("blk_valid", 32'(blk_valid), 32'(m_qlast.size() > 0));
        chk("blk_sel", 32'(blk_sel), 32'(rb));
        chk("blk_count", 32'(blk_count), 32'(m_bcount));
        chk("err_last", 32'(err_last), 32'(m_err));
        if (m_qlast.size() > 0)
            chk("blk_last", 32'(blk_last), 32'(m_qlast[0]));
        if (acc)
            chk("buf_wr_data", 32'(buf_wr_data), 32'(d));
        if (rel) begin
            for (int i = 0; i < 64; i++) img[i*12 +: 12] = tmem[rb][i];
            checks++;
            assert (img === m_qdata[0]) else begin
                errors++;
                $error("FAIL blk_data sel=%0d observed=%0h expected=%0h",
                       rb, img[95:0], m_qdata[0][95:0]);
            end
        end
        for (int b = 0; b < 2; b++)
            if (buf_wr_en[b]) tmem[b][pix_index] = buf_wr_data;
        @(posedge clock);
        if (rs) begin
            model_reset();
        end else begin
            if (rel) begin
                m_bcount = m_qlast[0] ? 0 : (m_bcount + 1) % 65536;
                void'(m_qlast.pop_front());
                void'(m_qdata.pop_front());
                m_rel++;
            end
            if (acc) begin
                m_cur[m_pcnt*12 +: 12] = d;
                if (m_pcnt == 63) begin
                    m_qlast.push_back(l);
                    m_qdata.push_back(m_cur);
                    m_done++;
                    m_pcnt = 0;
                end else begin
                    m_pcnt++;
                    if (l) m_err = 1;
                end
            end
        end
        @(negedge clock);
    endtask

    initial begin
        pix_valid = 0; pix_data = 0; pix_last = 0; blk_ready = 0; reset = 1;
        model_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 64; i++) tmem[b][i] = '0;
        @(negedge clock);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);

        // Two blocks with no consumer; pixel 127 flags end of frame.
        for (int i = 0; i < 128; i++)
            cyc(1, 12'(i), (i == 127), 0, 0);
        // Pixel 129 stalls while both buffers are full.
        for (int i = 0; i < 5; i++) cyc(1, 12'hABC, 0, 0, 0);
        cyc(1, 12'hABC, 0, 1, 0);
        cyc(1, 12'hABC, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // Continuous stream with an always-ready consumer.
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 256; i++)
            cyc(1, 12'($urandom), 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // Misplaced end-of-frame marker on pixel 40.
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 64; i++)
            cyc(1, 12'($urandom), (i == 40), 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);

        // Reset at pixel 30 with buffer 1 holding a block.
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 128; i++)
            cyc(1, 12'($urandom), 0, (i == 70), 0);
        for (int i = 0; i < 30; i++)
            cyc(1, 12'($urandom), 0, 0, 0);
        cyc(1, 12'h123, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);

        // Random traffic, including end-of-frame on a block boundary.
        for (int i = 0; i < 1500; i++) begin
            logic v;
            logic l;
            v = ($urandom % 4) != 0;
            l = (m_pcnt == 63) ? (($urandom % 3) == 0) : (($urandom % 200) == 0);
            cyc(v, 12'($urandom), l, ($urandom % 3) == 0, ($urandom % 500) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
